// File: rtl/int_to_flp_stream.sv
// int_to_flp_stream: streams a residue polynomial of length 2^len_log from the
// message BRAM into the FFT input BRAM as floating-point words.
//   clk, rst_n            clock, synchronous active-low reset
//   start                 run request, accepted in IDLE or DONE
//   pack_mode             0: {re,0} per coefficient, 1: coef i / i+N/2 packed
//   len_log, q            log2 length (clamped to LOGN) and modulus, latched on start
//   scale_power           result is scaled by 2^-scale_power, latched on start
//   rd_addr_a/b, rd_data_a/b  dual read port, data RD_LAT cycles after address
//   wr_addr, wr_data, wr_en   FFT BRAM write port, wr_data = {real, imag}
//   busy, done            busy in RUN/DRAIN, done level in DONE
`ifndef OVERALL_BITS
`define OVERALL_BITS 64
`endif
`ifndef EXPONENT_BITS
`define EXPONENT_BITS 11
`endif
module int_to_flp_stream #(
    parameter int LOGN     = 13,
    parameter int LOGQ     = 54,
    parameter int RD_LAT   = 2,
    parameter int CONV_LAT = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        pack_mode,
    input  logic [$clog2(LOGN+1)-1:0]   len_log,
    input  logic [LOGQ-1:0]             q,
    input  logic [`EXPONENT_BITS:0]     scale_power,
    output logic [LOGN-1:0]             rd_addr_a,
    output logic [LOGN-1:0]             rd_addr_b,
    input  logic [LOGQ-1:0]             rd_data_a,
    input  logic [LOGQ-1:0]             rd_data_b,
    output logic [LOGN-1:0]             wr_addr,
    output logic [2*`OVERALL_BITS-1:0]  wr_data,
    output logic                        wr_en,
    output logic                        busy,
    output logic                        done
);
    localparam int OB   = `OVERALL_BITS;
    localparam int EB   = `EXPONENT_BITS;
    localparam int MB   = OB - EB - 1;
    localparam int BIAS = 2**(EB-1) - 1;
    localparam int L    = RD_LAT + CONV_LAT;
    localparam int LW   = $clog2(LOGN+1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [LOGN-1:0] i, cnt_m1;
    logic            pk, pk_in, accept, issue;
    logic [LOGQ-1:0] q_r;
    logic [EB:0]     sp_r;
    logic [LW-1:0]   ll_c, eff;
    logic [LOGN:0]   cnt_in;
    logic [L-1:0]    vpipe;
    logic [LOGN-1:0] apipe [L];
    logic [2*OB-1:0] cpipe [CONV_LAT];

    // Centred residue (x > q/2 means x - q) scaled by 2^-sp. With LOGQ <= 54 the
    // magnitude fits the significand, so truncation below never drops set bits.
    function automatic logic [OB-1:0] flp(input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] qq,
                                          input logic [EB:0] sp);
        logic               neg;
        logic [LOGQ-1:0]    m, norm;
        logic [LOGQ+MB-2:0] ext;
        logic [EB-1:0]      e;
        int                 msb;
        neg = x > (qq >> 1);
        m = neg ? qq - x : x;
        msb = 0;
        for (int k = 0; k < LOGQ; k++) if (m[k]) msb = k;
        norm = m << (LOGQ - 1 - msb);
        ext = {norm[LOGQ-2:0], {MB{1'b0}}};
        e = EB'(msb + BIAS - int'(sp));
        return m == '0 ? '0 : {neg, e, ext[LOGQ+MB-2 -: MB]};
    endfunction

    assign accept = start && (state == IDLE || state == DONE);
    assign issue  = state == RUN;

    always_comb begin
        ll_c   = len_log > LW'(LOGN) ? LW'(LOGN) : len_log;
        pk_in  = pack_mode && len_log != '0;
        eff    = ll_c - LW'(pk_in);
        cnt_in = (LOGN+1)'(1) << eff;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN:        if (i == cnt_m1) state_nx = DRAIN;
            DRAIN:      if (i == LOGN'(L-1)) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = state == RUN || state == DRAIN;
        done      = state == DONE;
        rd_addr_a = issue ? i : '0;
        rd_addr_b = issue ? (pk ? i + cnt_m1 + LOGN'(1) : i) : '0;
    end

    // i counts read indices in RUN, then is reused as the drain cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i      <= '0;
            cnt_m1 <= '0;
            pk     <= 1'b0;
            q_r    <= '0;
            sp_r   <= '0;
            vpipe  <= '0;
            for (int k = 0; k < L; k++) apipe[k] <= '0;
        end else begin
            if (accept) begin
                i      <= '0;
                cnt_m1 <= LOGN'(cnt_in - (LOGN+1)'(1));
                pk     <= pk_in;
                q_r    <= q;
                sp_r   <= scale_power;
            end else if (state == RUN) begin
                i <= i == cnt_m1 ? '0 : i + LOGN'(1);
            end else if (state == DRAIN) begin
                i <= i + LOGN'(1);
            end
            vpipe    <= {vpipe[L-2:0], issue};
            apipe[0] <= issue ? i : '0;
            for (int k = 1; k < L; k++) apipe[k] <= apipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        cpipe[0] <= {flp(rd_data_a, q_r, sp_r), pk ? flp(rd_data_b, q_r, sp_r) : OB'(0)};
        for (int k = 1; k < CONV_LAT; k++) cpipe[k] <= cpipe[k-1];
    end

    assign wr_en   = vpipe[L-1];
    assign wr_addr = apipe[L-1];
    assign wr_data = cpipe[CONV_LAT-1];
endmodule

// File: tb/tb_int_to_flp_stream.sv
// tb_int_to_flp_stream: directed checks of int_to_flp_stream against a real-arithmetic model.
`ifndef OVERALL_BITS
`define OVERALL_BITS 64
`endif
`ifndef EXPONENT_BITS
`define EXPONENT_BITS 11
`endif
module tb_int_to_flp_stream;
    logic         clk = 0, rst_n = 0, start = 0, pack_mode = 0;
    logic [3:0]   len_log = 0;
    logic [53:0]  q = '1 - 54'd32;
    logic [11:0]  scale_power = 0;
    logic [12:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [53:0]  rd_data_a, rd_data_b;
    logic [127:0] wr_data;
    logic         wr_en, busy, done;
    logic [53:0]  mem [8192];
    logic [12:0]  pa [2], pb [2];
    logic [127:0] fd;
    int           vectors = 0, errs = 0;

    int_to_flp_stream dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pack_mode(pack_mode), .len_log(len_log),
        .q(q), .scale_power(scale_power), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_en(wr_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pa[0] <= rd_addr_a;
        pa[1] <= pa[0];
        pb[0] <= rd_addr_b;
        pb[1] <= pb[0];
    end
    assign rd_data_a = mem[pa[1]];
    assign rd_data_b = mem[pb[1]];

    function automatic logic [63:0] model(input logic [53:0] c, input logic [53:0] qq, input int sp);
        real r;
        r = c > (qq >> 1) ? -real'(longint'(qq - c)) : real'(longint'(c));
        return $realtobits(r * (2.0 ** (-sp)));
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input bit pk, input int ll, input int sp, input int n, input bit perturb,
                       output logic [127:0] first_data);
        bit pe = pk && ll != 0;
        int cnt = 0, cyc = 0, first = -1;
        first_data = 'x;
        @(negedge clk);
        pack_mode = pk; len_log = 4'(ll); scale_power = 12'(sp); start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        while (!done && cyc < 9000) begin
            if (perturb && cyc == 3) begin start = 1; len_log = 4'd1; pack_mode = ~pk; end
            if (perturb && cyc == 4) start = 0;
            if (cyc < n) begin
                chk("rd_addr_a", rd_addr_a, cyc);
                chk("rd_addr_b", rd_addr_b, pe ? cyc + n : cyc);
            end
            if (wr_en) begin
                if (first < 0) begin first = cyc; first_data = wr_data; end
                chk("wr_addr", wr_addr, cnt);
                chk("wr_data", wr_data, {model(mem[cnt], q, sp), pe ? model(mem[cnt+n], q, sp) : 64'd0});
                cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("first_wr_latency", first, 4);
        chk("write_count", cnt, n);
        chk("done_cycle", cyc, n + 4);
        chk("busy_at_done", busy, 0);
        chk("done_level", done, 1);
    endtask

    initial begin
        for (int k = 0; k < 8192; k++) mem[k] = 54'(k);
        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_addr_a", rd_addr_a, 0);
        chk("rst_rd_addr_b", rd_addr_b, 0);
        chk("rst_wr_addr", wr_addr, 0);
        rst_n = 1;

        run(0, 13, 0, 8192, 0, fd);

        for (int k = 0; k < 16; k++) mem[k] = k[0] ? q - 54'(k) : 54'(k * 1000 + 7);
        run(1, 4, 2, 8, 0, fd);

        mem[0] = q - 1; mem[1] = q >> 1; mem[2] = (q >> 1) + 1; mem[3] = 0;
        run(0, 2, 3, 4, 0, fd);
        chk("neg_one_scaled", fd, {64'hBFC0_0000_0000_0000, 64'd0});

        for (int k = 0; k < 64; k++) mem[k] = 54'(k * 3);
        run(0, 6, 1, 64, 1, fd);
        run(1, 6, 0, 32, 0, fd);

        @(negedge clk);
        pack_mode = 0; len_log = 4'd13; scale_power = 0; start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 200 && rd_addr_a != 13'd100; c++) @(negedge clk);
        chk("reached_i100", rd_addr_a, 100);
        chk("wr_en_before_reset", wr_en, 1);
        rst_n = 0;
        @(negedge clk);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rd_addr_a", rd_addr_a, 0);
        @(negedge clk);
        chk("abort_wr_en_hold", wr_en, 0);
        rst_n = 1;
        run(0, 5, 0, 32, 0, fd);

        run(1, 0, 0, 1, 0, fd);
        for (int k = 0; k < 8192; k++) mem[k] = 54'(8191 - k);
        run(0, 15, 0, 8192, 0, fd);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/int_to_flp_stream.md
Name: int_to_flp_stream

Overview:
- Parametrised successor to the fixed-length integer-to-floating-point wrapper that feeds the FFT BRAM.
- Converts a residue polynomial of runtime-selectable length N = 2^len_log into floating-point words, under a start/busy/done handshake.
- Real mode: writes {re, 0}, one word per coefficient.
- Pack mode: coefficients i and i+N/2 become the real and imaginary parts of complex word i, halving FFT input length.
- Sits between the message BRAM (dual read port) and the FFT input BRAM.

Parameters:
- LOGN, 13, address width; maximum N = 2^LOGN.
- LOGQ, 54, coefficient and modulus width.
- RD_LAT, 2, message BRAM read latency in cycles.
- CONV_LAT, 2, latency of each IntToFlPDouble lane.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  single-cycle request; sampled only in IDLE or DONE.
- pack_mode  in  1  0 = real mode, 1 = complex pack mode; latched on start.
- len_log  in  $clog2(LOGN+1)  log2 of N, valid range 0..LOGN; latched on start.
- q  in  LOGQ  modulus passed to both lanes; latched on start.
- scale_power  in  `EXPONENT_BITS+1  scaling exponent; latched on start.
- rd_addr_a  out  LOGN  read address of lane A (real part).
- rd_addr_b  out  LOGN  read address of lane B (imaginary part).
- rd_data_a  in  LOGQ  lane A data, RD_LAT cycles after its address.
- rd_data_b  in  LOGQ  lane B data, RD_LAT cycles after its address.
- wr_addr  out  LOGN  FFT BRAM write address.
- wr_data  out  2*`OVERALL_BITS  {real, imag} floating-point word.
- wr_en  out  1  write strobe.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  level; high in DONE until the next accepted start or reset.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state = IDLE; all counters and the valid pipeline are cleared.
  - wr_en = 0, busy = 0, done = 0, rd_addr_a = rd_addr_b = 0, wr_addr = 0.
  - Reset mid-operation aborts the run; wr_en is low from the cycle after the reset edge, with no trailing writes.
- Configuration:
  - Effective count: CNT = 2^len_log in real mode, CNT = 2^(len_log-1) in pack mode.
  - pack_mode with len_log = 0 is treated as real mode.
  - len_log > LOGN is clamped to LOGN.
  - All configuration inputs are latched on the accepted start; later input changes have no effect until the next start.
- State machine:
  - IDLE --start--> RUN.
  - RUN issues one read index i per cycle, i = 0..CNT-1, with rd_addr_a = i and rd_addr_b = i + CNT in pack mode, else rd_addr_b = i.
  - RUN --(i = CNT-1 issued)--> DRAIN.
  - DRAIN lasts RD_LAT+CONV_LAT cycles, until the last write retires, then goes to DONE.
  - DONE --start--> RUN (back-to-back runs are allowed).
  - start in RUN or DRAIN is ignored.
- Pipeline:
  - A valid bit and index i travel through a RD_LAT+CONV_LAT delay line.
  - wr_en asserts exactly RD_LAT+CONV_LAT cycles after the cycle index i was issued, with wr_addr = i.
  - Exactly CNT writes occur per run, at consecutive addresses 0..CNT-1, with no gaps.
- Data:
  - Lane A converts rd_data_a and lane B converts rd_data_b, both using the latched q and scale_power.
  - Pack mode: wr_data = {flp(A), flp(B)}.
  - Real mode: wr_data = {flp(A), `OVERALL_BITS'd0}; lane B output is ignored.
- Timing: done rises in the cycle after the last write; busy falls in that same cycle.
- In IDLE and DONE, rd_addr_a and rd_addr_b hold 0.

Test Plan:
1. Real mode, len_log = 13, coefficient k = k, q = 2^54-33 → 8192 writes at addr 0..8191, wr_data[imag] = 0, first wr_en 4 cycles after the first read, done 1 cycle after addr 8191.
2. Pack mode, len_log = 4 → 8 writes; word i = {flp(coef i), flp(coef i+8)}; rd_addr_b steps 8..15; done asserts after 1+8+4 cycles.
3. Coefficient q-1 in real mode → flp(-1·2^-scale), i.e. the centred negative value, matching a reference model bit-exactly.
4. Reset asserted mid-RUN at i = 100 → wr_en low from the next cycle, busy = done = 0; a new start runs a complete transfer from addr 0.
5. start pulsed during RUN, and len_log changed during RUN → both ignored, write count unchanged; a start in DONE launches a second run back-to-back.
6. Edge cases: pack_mode = 1 with len_log = 0 → one real-mode write at addr 0; len_log = 15 with LOGN = 13 → clamped, 8192 writes.
